// File: rtl/pulse_stretch.sv
// Multi-channel pulse stretcher: widens single-cycle events into LED-visible levels
// measured in prescaler ticks, with a forced one-tick low gap after each stretch.
module pulse_stretch #(
    parameter int unsigned CHANNELS   = 8,
    parameter int unsigned PRESCALE   = 50000,
    parameter int unsigned HOLD_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [CHANNELS-1:0]   IN,
    input  logic [HOLD_WIDTH-1:0] HOLD,
    input  logic                  RETRIG,
    output logic [CHANNELS-1:0]   OUT,
    output logic                  TICK,
    output logic                  BUSY
);

    localparam int unsigned PreW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic [1:0] {StIdle, StActive, StGap} state_e;

    logic [PreW-1:0]       pre_q, pre_d;
    logic                  tick_d;
    logic [HOLD_WIDTH-1:0] hold_eff;

    state_e                state_q [CHANNELS];
    state_e                state_d [CHANNELS];
    logic [HOLD_WIDTH-1:0] cnt_q   [CHANNELS];
    logic [HOLD_WIDTH-1:0] cnt_d   [CHANNELS];
    logic [CHANNELS-1:0]   pend_q, pend_d;
    logic [CHANNELS-1:0]   out_d;
    logic                  busy_d;

    // TICK is registered from the next count so it lines up with pre_q == PRESCALE-1.
    always_comb begin
        if (pre_q == PreW'(PRESCALE - 1)) begin
            pre_d = '0;
        end else begin
            pre_d = pre_q + PreW'(1);
        end
        tick_d = (pre_d == PreW'(PRESCALE - 1));
    end

    assign hold_eff = (HOLD == '0) ? HOLD_WIDTH'(1) : HOLD;

    always_comb begin
        busy_d = 1'b0;
        out_d  = '0;
        pend_d = pend_q;
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            unique case (state_q[i])
                StIdle: begin
                    if (IN[i]) begin
                        state_d[i] = StActive;
                        cnt_d[i]   = hold_eff;
                        pend_d[i]  = 1'b0;
                    end
                end
                StActive: begin
                    // A retrigger reload beats a coincident final tick.
                    if (IN[i] && RETRIG) begin
                        cnt_d[i] = hold_eff;
                    end else begin
                        if (IN[i]) begin
                            pend_d[i] = 1'b1;
                        end
                        if (TICK) begin
                            if (cnt_q[i] <= HOLD_WIDTH'(1)) begin
                                state_d[i] = StGap;
                                cnt_d[i]   = '0;
                            end else begin
                                cnt_d[i] = cnt_q[i] - HOLD_WIDTH'(1);
                            end
                        end
                    end
                end
                StGap: begin
                    if (TICK) begin
                        if (pend_q[i] || IN[i]) begin
                            state_d[i] = StActive;
                            cnt_d[i]   = hold_eff;
                            pend_d[i]  = 1'b0;
                        end else begin
                            state_d[i] = StIdle;
                        end
                    end else if (IN[i]) begin
                        pend_d[i] = 1'b1;
                    end
                end
                default: begin
                    state_d[i] = StIdle;
                    cnt_d[i]   = '0;
                    pend_d[i]  = 1'b0;
                end
            endcase
            out_d[i] = (state_d[i] == StActive);
            if (state_d[i] != StIdle) begin
                busy_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            pre_q  <= '0;
            TICK   <= 1'b0;
            OUT    <= '0;
            BUSY   <= 1'b0;
            pend_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= StIdle;
                cnt_q[i]   <= '0;
            end
        end else begin
            pre_q  <= pre_d;
            TICK   <= tick_d;
            OUT    <= out_d;
            BUSY   <= busy_d;
            pend_q <= pend_d;
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

endmodule

// File: tb/tb_pulse_stretch.sv
// Directed bench for pulse_stretch with PRESCALE=4: ticks fall on cycles 3, 7, 11, ...
module tb_pulse_stretch;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [7:0] IN = 8'h00;
    logic [7:0] HOLD = 8'h00;
    logic       RETRIG = 1'b0;
    logic [7:0] OUT;
    logic       TICK;
    logic       BUSY;

    int checks = 0;
    int errors = 0;

    pulse_stretch #(
        .CHANNELS   (8),
        .PRESCALE   (4),
        .HOLD_WIDTH (8)
    ) dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .IN     (IN),
        .HOLD   (HOLD),
        .RETRIG (RETRIG),
        .OUT    (OUT),
        .TICK   (TICK),
        .BUSY   (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Values for cycle c are visible between edge c-1 and edge c.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_cycle(input string scn, input int c, input logic [7:0] eo,
                               input logic et, input logic eb);
        check($sformatf("%s OUT c%0d", scn, c), 32'(OUT), 32'(eo));
        check($sformatf("%s TICK c%0d", scn, c), 32'(TICK), 32'(et));
        check($sformatf("%s BUSY c%0d", scn, c), 32'(BUSY), 32'(eb));
    endtask

    function automatic logic tk(input int c);
        return (c % 4) == 3;
    endfunction

    // Leaves the bench at the start of cycle 0, the first edge after release.
    task automatic reset_dut();
        RST_N = 1'b0;
        IN    = 8'hFF;
        for (int r = 0; r < 3; r++) begin
            step();
            check_cycle("reset", r, 8'h00, 1'b0, 1'b0);
        end
        RST_N = 1'b1;
        IN    = 8'h00;
    endtask

    initial begin
        // Single event, HOLD=3
        reset_dut();
        HOLD = 8'd3;
        RETRIG = 1'b0;
        for (int c = 0; c < 26; c++) begin
            check_cycle("single", c, (c >= 6 && c <= 15) ? 8'h01 : 8'h00, tk(c),
                        c >= 6 && c <= 19);
            IN = (c == 5) ? 8'h01 : 8'h00;
            step();
        end

        // Retrigger extends the stretch
        reset_dut();
        RETRIG = 1'b1;
        for (int c = 0; c < 28; c++) begin
            check_cycle("retrig", c, (c >= 6 && c <= 19) ? 8'h01 : 8'h00, tk(c),
                        c >= 6 && c <= 23);
            IN = (c == 5 || c == 10) ? 8'h01 : 8'h00;
            step();
        end

        // Pending restart after the gap; third pulse coalesces
        reset_dut();
        RETRIG = 1'b0;
        for (int c = 0; c < 42; c++) begin
            check_cycle("pending", c,
                        ((c >= 6 && c <= 15) || (c >= 20 && c <= 31)) ? 8'h01 : 8'h00,
                        tk(c), c >= 6 && c <= 35);
            IN = (c == 5 || c == 10 || c == 12) ? 8'h01 : 8'h00;
            step();
        end

        // HOLD=0 behaves as 1 on two channels at once
        reset_dut();
        HOLD = 8'd0;
        for (int c = 0; c < 16; c++) begin
            check_cycle("hold0", c, (c >= 6 && c <= 7) ? 8'h82 : 8'h00, tk(c),
                        c >= 6 && c <= 11);
            IN = (c == 5) ? 8'h82 : 8'h00;
            step();
        end

        // Retrigger on the final tick keeps the channel active
        reset_dut();
        HOLD = 8'd1;
        RETRIG = 1'b1;
        for (int c = 0; c < 20; c++) begin
            check_cycle("retrig_last", c, (c >= 6 && c <= 11) ? 8'h01 : 8'h00, tk(c),
                        c >= 6 && c <= 15);
            IN = (c == 5 || c == 7) ? 8'h01 : 8'h00;
            step();
        end

        // Event on the gap-ending tick restarts immediately
        reset_dut();
        RETRIG = 1'b0;
        for (int c = 0; c < 24; c++) begin
            check_cycle("gap_tick", c,
                        ((c >= 6 && c <= 7) || (c >= 12 && c <= 15)) ? 8'h01 : 8'h00,
                        tk(c), c >= 6 && c <= 19);
            IN = (c == 5 || c == 11) ? 8'h01 : 8'h00;
            step();
        end

        // Reset mid-operation drops pending; IN ignored during reset
        reset_dut();
        HOLD = 8'd3;
        for (int c = 0; c < 42; c++) begin
            check_cycle("rst_mid", c, (c >= 6 && c <= 15) ? 8'h01 : 8'h00,
                        (c < 18) ? tk(c) : tk(c - 18), c >= 6 && c <= 17);
            RST_N = (c == 17) ? 1'b0 : 1'b1;
            IN = (c == 5 || c == 10 || c == 12) ? 8'h01 : ((c == 17) ? 8'hFF : 8'h00);
            step();
        end

        // Maximum HOLD counts all 255 ticks without wrapping
        reset_dut();
        HOLD = 8'hFF;
        for (int c = 0; c < 1034; c++) begin
            check_cycle("hold_max", c, (c >= 6 && c <= 1023) ? 8'h01 : 8'h00, tk(c),
                        c >= 6 && c <= 1027);
            IN = (c == 5) ? 8'h01 : 8'h00;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
